// File: rtl/control_decode_stage.sv
// control_decode_stage
//   Registered main decoder for a 5-stage RV32I pipeline. The opcode and
//   funct fields of the instruction in ID are decoded combinationally and
//   captured into the ID/EX control register on each rising clock edge.
//   Flush loads a bubble, Stall holds the register, and illegal encodings
//   are flagged and counted.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   InValid           ID holds a valid instruction
//   Stall             hold the ID/EX control register (counter frozen)
//   Flush             load a bubble; wins over Stall
//   Op/funct3/funct7  instruction fields from ID
//   ExValid           EX holds a valid, legal instruction
//   RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ImmSrc, ALUControl
//                     registered control for EX and later stages
//   Illegal           an illegal instruction was loaded into EX
//   IllegalCount      saturating count of illegal instructions loaded
module control_decode_stage #(
  parameter int ALUCTRL_W = 4,
  parameter bit EN_JUMP   = 1'b1,
  parameter int ILLCNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 InValid,
  input  logic                 Stall,
  input  logic                 Flush,
  input  logic [6:0]           Op,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  output logic                 ExValid,
  output logic                 RegWrite,
  output logic                 ALUSrc,
  output logic                 MemWrite,
  output logic [1:0]           ResultSrc,
  output logic                 Branch,
  output logic                 Jump,
  output logic [2:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Illegal,
  output logic [ILLCNT_W-1:0]  IllegalCount
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       alusrc;
    logic       memwrite;
    logic [1:0] resultsrc;
    logic       branch;
    logic       jump;
    logic [2:0] immsrc;
    logic [3:0] aluop;
    logic       illegal;
  } ctrl_t;

  ctrl_t               ctrl_reg;
  ctrl_t               ctrl_next;
  logic [ILLCNT_W-1:0] illcnt_reg;

  // Shared R/I arithmetic decode. SUB exists only for R-type; for I-type
  // funct7 is immediate bits except on the shift-right encodings.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic is_r,
                                          input logic alt);
    logic [3:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  always_comb begin
    logic bad;
    ctrl_next = '0;
    bad       = 1'b0;
    case (Op)
      OP_LOAD: begin
        ctrl_next.regwrite  = 1'b1;
        ctrl_next.alusrc    = 1'b1;
        ctrl_next.resultsrc = 2'b01;
        ctrl_next.immsrc    = 3'b000;
        ctrl_next.aluop     = ALU_ADD;
        bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        ctrl_next.alusrc   = 1'b1;
        ctrl_next.memwrite = 1'b1;
        ctrl_next.immsrc   = 3'b001;
        ctrl_next.aluop    = ALU_ADD;
        bad = (funct3 > 3'b010);
      end
      OP_R: begin
        ctrl_next.regwrite = 1'b1;
        ctrl_next.aluop    = arith_op(funct3, 1'b1, funct7[5]);
        bad = ((funct7 != F7_ZERO) && (funct7 != F7_ALT)) ||
              ((funct7 == F7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101));
      end
      OP_I: begin
        ctrl_next.regwrite = 1'b1;
        ctrl_next.alusrc   = 1'b1;
        ctrl_next.immsrc   = 3'b000;
        // funct7[5] selects SRA only on the shift-right encoding
        ctrl_next.aluop    = arith_op(funct3, 1'b0, (funct3 == 3'b101) && funct7[5]);
        bad = ((funct3 == 3'b001) && (funct7 != F7_ZERO)) ||
              ((funct3 == 3'b101) && (funct7 != F7_ZERO) && (funct7 != F7_ALT));
      end
      OP_BRANCH: begin
        ctrl_next.branch = 1'b1;
        ctrl_next.immsrc = 3'b010;
        ctrl_next.aluop  = ALU_SUB;
        bad = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        ctrl_next.regwrite  = 1'b1;
        ctrl_next.jump      = 1'b1;
        ctrl_next.resultsrc = 2'b10;
        ctrl_next.immsrc    = 3'b011;
        bad = !EN_JUMP;
      end
      OP_JALR: begin
        ctrl_next.regwrite  = 1'b1;
        ctrl_next.jump      = 1'b1;
        ctrl_next.alusrc    = 1'b1;
        ctrl_next.resultsrc = 2'b10;
        ctrl_next.immsrc    = 3'b000;
        ctrl_next.aluop     = ALU_ADD;
        bad = !EN_JUMP || (funct3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase
    // An illegal instruction travels down the pipe as a flagged bubble
    if (bad) begin
      ctrl_next         = '0;
      ctrl_next.illegal = 1'b1;
    end else begin
      ctrl_next.valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg   <= '0;
      illcnt_reg <= '0;
    end else if (Flush) begin
      ctrl_reg <= '0;
    end else if (Stall) begin
      ctrl_reg <= ctrl_reg;
    end else if (InValid) begin
      ctrl_reg <= ctrl_next;
      if (ctrl_next.illegal && (illcnt_reg != {ILLCNT_W{1'b1}}))
        illcnt_reg <= illcnt_reg + ILLCNT_W'(1);
    end else begin
      ctrl_reg <= '0;
    end
  end

  assign ExValid          = ctrl_reg.valid;
  assign RegWrite         = ctrl_reg.regwrite;
  assign ALUSrc           = ctrl_reg.alusrc;
  assign MemWrite         = ctrl_reg.memwrite;
  assign ResultSrc        = ctrl_reg.resultsrc;
  assign Branch           = ctrl_reg.branch;
  assign Jump             = ctrl_reg.jump;
  assign ImmSrc           = ctrl_reg.immsrc;
  assign Illegal          = ctrl_reg.illegal;
  assign IllegalCount     = illcnt_reg;
  assign ALUControl[3:0]  = ctrl_reg.aluop;

  // Widths above the 4-bit op code are always zero
  genvar gi;
  generate
    for (gi = 4; gi < ALUCTRL_W; gi++) begin : g_alu_pad
      assign ALUControl[gi] = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_control_decode_stage.sv
module tb_control_decode_stage;

  logic       clk = 1'b0;
  logic       rst, InValid, Stall, Flush;
  logic [6:0] Op, funct7;
  logic [2:0] funct3;

  // main instance: default parameters
  logic       ExValid, RegWrite, ALUSrc, MemWrite, Branch, Jump, Illegal;
  logic [1:0] ResultSrc;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic [7:0] IllegalCount;

  // small instance: 2-bit counter, jumps disabled, 6-bit ALUControl
  logic       s_ExValid, s_RegWrite, s_ALUSrc, s_MemWrite, s_Branch, s_Jump, s_Illegal;
  logic [1:0] s_ResultSrc;
  logic [2:0] s_ImmSrc;
  logic [5:0] s_ALUControl;
  logic [1:0] s_IllegalCount;

  int vec_cnt  = 0;
  int fail_cnt = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  control_decode_stage u_dut (
    .clk(clk), .rst(rst), .InValid(InValid), .Stall(Stall), .Flush(Flush),
    .Op(Op), .funct3(funct3), .funct7(funct7),
    .ExValid(ExValid), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
    .ResultSrc(ResultSrc), .Branch(Branch), .Jump(Jump), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .Illegal(Illegal), .IllegalCount(IllegalCount)
  );

  control_decode_stage #(.ALUCTRL_W(6), .EN_JUMP(1'b0), .ILLCNT_W(2)) u_small (
    .clk(clk), .rst(rst), .InValid(InValid), .Stall(Stall), .Flush(Flush),
    .Op(Op), .funct3(funct3), .funct7(funct7),
    .ExValid(s_ExValid), .RegWrite(s_RegWrite), .ALUSrc(s_ALUSrc), .MemWrite(s_MemWrite),
    .ResultSrc(s_ResultSrc), .Branch(s_Branch), .Jump(s_Jump), .ImmSrc(s_ImmSrc),
    .ALUControl(s_ALUControl), .Illegal(s_Illegal), .IllegalCount(s_IllegalCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected control word: {valid,rw,alusrc,memwrite,rs[1:0],branch,jump,imm[2:0],alu[3:0],illegal}
  function automatic logic [15:0] ctl(input logic v, input logic rw, input logic as,
                                      input logic mw, input logic [1:0] rs, input logic br,
                                      input logic j, input logic [2:0] imm,
                                      input logic [3:0] alu, input logic ill);
    return {v, rw, as, mw, rs, br, j, imm, alu, ill};
  endfunction

  function automatic logic [15:0] obs_main();
    return {ExValid, RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ImmSrc,
            ALUControl, Illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    Op = op; funct3 = f3; funct7 = f7;
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [15:0] exp);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.exp = exp;
    vecs.push_back(v);
  endtask

  logic [15:0] ILL, JAL_W, LOAD_W, STORE_W;

  initial begin
    ILL     = ctl(0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 4'h0, 1);
    JAL_W   = ctl(1, 1, 0, 0, 2'b10, 0, 1, 3'b011, 4'h0, 0);
    LOAD_W  = ctl(1, 1, 1, 0, 2'b01, 0, 0, 3'b000, 4'h0, 0);
    STORE_W = ctl(1, 0, 1, 1, 2'b00, 0, 0, 3'b001, 4'h0, 0);

    // R-type
    add(7'h33, 3'd0, 7'h20, ctl(1, 1, 0, 0, 2'b00, 0, 0, 3'b000, 4'h1, 0)); // SUB
    add(7'h33, 3'd0, 7'h00, ctl(1, 1, 0, 0, 2'b00, 0, 0, 3'b000, 4'h0, 0)); // ADD
    add(7'h33, 3'd1, 7'h00, ctl(1, 1, 0, 0, 2'b00, 0, 0, 3'b000, 4'h7, 0)); // SLL
    add(7'h33, 3'd2, 7'h00, ctl(1, 1, 0, 0, 2'b00, 0, 0, 3'b000, 4'h5, 0)); // SLT
    add(7'h33, 3'd3, 7'h00, ctl(1, 1, 0, 0, 2'b00, 0, 0, 3'b000, 4'h6, 0)); // SLTU
    add(7'h33, 3'd4, 7'h00, ctl(1, 1, 0, 0, 2'b00, 0, 0, 3'b000, 4'h4, 0)); // XOR
    add(7'h33, 3'd5, 7'h00, ctl(1, 1, 0, 0, 2'b00, 0, 0, 3'b000, 4'h8, 0)); // SRL
    add(7'h33, 3'd5, 7'h20, ctl(1, 1, 0, 0, 2'b00, 0, 0, 3'b000, 4'h9, 0)); // SRA
    add(7'h33, 3'd6, 7'h00, ctl(1, 1, 0, 0, 2'b00, 0, 0, 3'b000, 4'h3, 0)); // OR
    add(7'h33, 3'd7, 7'h00, ctl(1, 1, 0, 0, 2'b00, 0, 0, 3'b000, 4'h2, 0)); // AND
    add(7'h33, 3'd0, 7'h01, ILL);                                           // bad funct7
    add(7'h33, 3'd1, 7'h20, ILL);                                           // alt SLL
    // I-type
    add(7'h13, 3'd0, 7'h20, ctl(1, 1, 1, 0, 2'b00, 0, 0, 3'b000, 4'h0, 0)); // ADDI, no SUB
    add(7'h13, 3'd5, 7'h20, ctl(1, 1, 1, 0, 2'b00, 0, 0, 3'b000, 4'h9, 0)); // SRAI
    add(7'h13, 3'd5, 7'h01, ILL);                                           // SRAI bad f7
    add(7'h13, 3'd5, 7'h00, ctl(1, 1, 1, 0, 2'b00, 0, 0, 3'b000, 4'h8, 0)); // SRLI
    add(7'h13, 3'd1, 7'h00, ctl(1, 1, 1, 0, 2'b00, 0, 0, 3'b000, 4'h7, 0)); // SLLI
    add(7'h13, 3'd1, 7'h20, ILL);                                           // SLLI bad f7
    add(7'h13, 3'd2, 7'h7f, ctl(1, 1, 1, 0, 2'b00, 0, 0, 3'b000, 4'h5, 0)); // SLTI
    add(7'h13, 3'd3, 7'h00, ctl(1, 1, 1, 0, 2'b00, 0, 0, 3'b000, 4'h6, 0)); // SLTIU
    add(7'h13, 3'd4, 7'h00, ctl(1, 1, 1, 0, 2'b00, 0, 0, 3'b000, 4'h4, 0)); // XORI
    add(7'h13, 3'd6, 7'h00, ctl(1, 1, 1, 0, 2'b00, 0, 0, 3'b000, 4'h3, 0)); // ORI
    add(7'h13, 3'd7, 7'h00, ctl(1, 1, 1, 0, 2'b00, 0, 0, 3'b000, 4'h2, 0)); // ANDI
    // memory, branch, jump, bad opcode
    add(7'h03, 3'd2, 7'h00, LOAD_W);
    add(7'h03, 3'd4, 7'h00, LOAD_W);
    add(7'h03, 3'd3, 7'h00, ILL);
    add(7'h03, 3'd6, 7'h00, ILL);
    add(7'h23, 3'd2, 7'h00, STORE_W);
    add(7'h23, 3'd3, 7'h00, ILL);
    add(7'h63, 3'd0, 7'h00, ctl(1, 0, 0, 0, 2'b00, 1, 0, 3'b010, 4'h1, 0));
    add(7'h63, 3'd7, 7'h00, ctl(1, 0, 0, 0, 2'b00, 1, 0, 3'b010, 4'h1, 0));
    add(7'h63, 3'd2, 7'h00, ILL);
    add(7'h6f, 3'd5, 7'h00, JAL_W);
    add(7'h67, 3'd0, 7'h00, ctl(1, 1, 1, 0, 2'b10, 0, 1, 3'b000, 4'h0, 0)); // JALR
    add(7'h67, 3'd1, 7'h00, ILL);
    add(7'h37, 3'd0, 7'h00, ILL);                                           // LUI: unsupported

    // reset state
    rst = 1'b1; InValid = 1'b0; Stall = 1'b0; Flush = 1'b0;
    present(7'h33, 3'd0, 7'h20);
    step(); step();
    check("reset_ctl", 32'(obs_main()), 32'h0);
    check("reset_cnt", 32'(IllegalCount), 32'd0);
    check("reset_small_cnt", 32'(s_IllegalCount), 32'd0);

    // decode table
    rst = 1'b0; InValid = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      present(vecs[i].op, vecs[i].f3, vecs[i].f7);
      step();
      if (vecs[i].exp[0]) exp_cnt++;
      $display("vec %0d op=%b f3=%b f7=%b ctl=%h", i, vecs[i].op, vecs[i].f3, vecs[i].f7, obs_main());
      check($sformatf("decode%0d_ctl", i), 32'(obs_main()), 32'(vecs[i].exp));
      check($sformatf("decode%0d_cnt", i), 32'(IllegalCount), 32'(exp_cnt));
    end

    // JAL held through a 3-cycle stall while a LOAD waits in ID
    present(7'h6f, 3'd0, 7'h00);
    step();
    check("jal_ctl", 32'(obs_main()), 32'(JAL_W));
    check("nojump_illegal", 32'(s_Illegal), 32'd1);
    check("nojump_jump", 32'(s_Jump), 32'd0);
    Stall = 1'b1;
    present(7'h03, 3'd2, 7'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d_ctl", i), 32'(obs_main()), 32'(JAL_W));
      check($sformatf("stall%0d_small_ill", i), 32'(s_Illegal), 32'd1);
    end
    Stall = 1'b0;
    step();
    check("after_stall_load", 32'(obs_main()), 32'(LOAD_W));
    check("after_stall_small_ill", 32'(s_Illegal), 32'd0);

    // illegal presented under stall must not count
    Stall = 1'b1;
    present(7'h7f, 3'd0, 7'h00);
    step();
    check("stall_ill_ctl", 32'(obs_main()), 32'(LOAD_W));
    check("stall_ill_cnt", 32'(IllegalCount), 32'(exp_cnt));

    // Flush beats Stall
    Flush = 1'b1;
    present(7'h23, 3'd2, 7'h00);
    step();
    check("flush_memwrite", 32'(MemWrite), 32'd0);
    check("flush_exvalid", 32'(ExValid), 32'd0);
    check("flush_ctl", 32'(obs_main()), 32'h0);
    Flush = 1'b0; Stall = 1'b0;
    step();
    check("store_ctl", 32'(obs_main()), 32'(STORE_W));

    // flush of an illegal: bubble, counter unchanged
    Flush = 1'b1;
    present(7'h7f, 3'd0, 7'h00);
    step();
    check("flush_ill_ctl", 32'(obs_main()), 32'h0);
    check("flush_ill_cnt", 32'(IllegalCount), 32'(exp_cnt));
    Flush = 1'b0;

    // no valid instruction: bubble, counter holds
    InValid = 1'b0;
    step();
    check("invalid_ctl", 32'(obs_main()), 32'h0);
    check("invalid_cnt", 32'(IllegalCount), 32'(exp_cnt));

    // reset mid-stream while a SUB is being loaded
    InValid = 1'b1; rst = 1'b1;
    present(7'h33, 3'd0, 7'h20);
    step();
    check("midrst_ctl", 32'(obs_main()), 32'h0);
    check("midrst_cnt", 32'(IllegalCount), 32'd0);
    check("midrst_small_cnt", 32'(s_IllegalCount), 32'd0);
    rst = 1'b0;

    // saturation of the 2-bit counter: 1,2,3,3,3
    present(7'h7f, 3'd0, 7'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("sat%0d_ctl", i), 32'(obs_main()), 32'(ILL));
      check($sformatf("sat%0d_cnt", i), 32'(IllegalCount), 32'(i + 1));
      check($sformatf("sat%0d_small_cnt", i), 32'(s_IllegalCount), 32'((i < 3) ? i + 1 : 3));
    end

    // wide ALUControl upper bits stay zero
    present(7'h33, 3'd5, 7'h20);
    step();
    check("wide_alu_sra", 32'(s_ALUControl), 32'd9);
    check("small_cnt_hold", 32'(s_IllegalCount), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
